// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned PRESCALE_W = 6;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period counter: strobes bit_end on the last clk of each bit time.
// It restarts from zero whenever the FSM enters a new state.
module uart_tx_bit_timer
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  bit_end
);

    logic [PRESCALE_W-1:0] cnt_q;

    // prescale arrives already clamped to at least 1
    assign bit_end = (cnt_q == prescale - PRESCALE_W'(1));

    always_ff @(posedge clk) begin
        if (rst || restart || bit_end) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_W bits MSB first, optional parity, stop.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     P_DATA,
    input  logic                  data_valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    tx_state_t             state_q, state_d;
    logic [DATA_W-1:0]     data_q;
    logic [PRESCALE_W-1:0] ps_q;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, done_q;
    logic                  bit_end;
    logic                  restart;
    logic                  accept;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_typ_q, par_bit;
    assign par_bit = par_typ_q ? ~^data_q : ^data_q;
`else
    logic unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
`endif

    assign accept  = (state_q == IDLE) && data_valid;
    assign restart = (state_q == IDLE) || (state_d != state_q);

    uart_tx_bit_timer u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .prescale (ps_q),
        .bit_end  (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE:  if (data_valid) state_d = START;
            START: if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? PARITY : STOP;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_d = STOP;
`endif
            STOP:  if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Line level is decoded from the next state so TX_OUT stays a pure flop.
    always_comb begin
        tx_d = IDLE_LVL;
        case (state_d)
            IDLE:   tx_d = IDLE_LVL;
            START:  tx_d = START_LVL;
            DATA:   tx_d = data_q[LAST - bit_cnt_d];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = par_bit;
`endif
            STOP:   tx_d = STOP_LVL;
            default: tx_d = IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            tx_q      <= IDLE_LVL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_q == STOP) && bit_end;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            ps_q      <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
`endif
        end else if (accept) begin
            data_q    <= P_DATA;
            ps_q      <= (prescale == '0) ? PRESCALE_W'(1) : prescale;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
`endif
        end
    end

    assign TX_OUT  = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized self-checking bench for uart_tx against a frame-level model.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx;

    localparam int unsigned DATA_W = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] P_DATA;
    logic              data_valid;
    logic              PAR_EN;
    logic              PAR_TYP;
    logic [5:0]        prescale;
    logic              TX_OUT;
    logic              busy;
    logic              tx_done;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned cyc         = 0;
    int unsigned last_done   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input bit done_exp);
        check_eq({tag, "_tx"},   TX_OUT,  1);
        check_eq({tag, "_busy"}, busy,    0);
        check_eq({tag, "_done"}, tx_done, done_exp);
    endtask

    // Sends one frame and checks every cycle of it. inject_at re-pulses
    // data_valid with 8'hFF mid-frame; reset_at asserts rst on that edge.
    task automatic send_frame(input logic [7:0] d, input bit pe, input bit pt,
                              input logic [5:0] ps, input int inject_at,
                              input int reset_at, input bit hold_dv);
        bit q[$];
        int ps_eff;
        int n;
        int ones;
        ps_eff = (ps == 0) ? 1 : int'(ps);
        q.push_back(1'b0);
        for (int i = DATA_W - 1; i >= 0; i--) q.push_back(d[i]);
        if (pe && PAR_BUILT) begin
            ones = $countones(d);
            q.push_back(pt ? ((ones % 2) == 0) : ((ones % 2) == 1));
        end
        q.push_back(1'b1);
        n = q.size() * ps_eff;

        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; prescale = ps; data_valid = 1'b1;
        step;
        if (!hold_dv) data_valid = 1'b0;
        P_DATA = 8'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
        prescale = 6'($urandom);

        for (int k = 0; k < n; k++) begin
            check_eq("tx_out", TX_OUT, q[k / ps_eff]);
            check_eq("busy", busy, 1);
            check_eq("done_early", tx_done, 0);
            if (k == inject_at) begin
                data_valid = 1'b1;
                P_DATA = 8'hFF;
            end else if (!hold_dv) begin
                data_valid = 1'b0;
            end
            if (k + 1 == reset_at) begin
                rst = 1'b1;
                step;
                check_idle("mid_rst", 0);
                rst = 1'b0;
                step;
                check_idle("post_rst", 0);
                return;
            end
            step;
        end
        check_idle("frame_end", 1);
        last_done = cyc;
        if (!hold_dv) begin
            step;
            check_idle("after_done", 0);
        end
    endtask

    initial begin
        int unsigned t1;
        rst = 1'b1; data_valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0;
        PAR_TYP = 1'b0; prescale = '0;
        repeat (5) step;
        check_idle("reset", 0);

        data_valid = 1'b1;
        step;
        check_idle("dv_in_reset", 0);
        data_valid = 1'b0;
        rst = 1'b0;
        step;
        check_idle("idle", 0);

        send_frame(8'h09, 1, 1, 6'd8, -1, -1, 0);
        send_frame(8'h09, 1, 0, 6'd8, -1, -1, 0);
        send_frame(8'h09, 0, 1, 6'd8, -1, -1, 0);
        send_frame(8'h09, 1, 1, 6'd8, 20, -1, 0);
        send_frame(8'h09, 1, 1, 6'd8, -1, 30, 0);
        send_frame(8'h09, 1, 1, 6'd8, -1, -1, 0);
        send_frame(8'hA5, 0, 0, 6'd0, -1, -1, 0);

        send_frame(8'h3C, 0, 0, 6'd4, -1, -1, 1);
        t1 = last_done;
        send_frame(8'hC3, 0, 0, 6'd4, -1, -1, 1);
        check_eq("b2b_period", last_done - t1, 41);
        t1 = last_done;
        send_frame(8'h81, 0, 0, 6'd4, -1, -1, 0);
        check_eq("b2b_period2", last_done - t1, 41);

        for (int r = 0; r < 25; r++) begin
            send_frame(8'($urandom), 1'($urandom), 1'($urandom),
                       6'($urandom_range(7, 0)), -1, -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001: Parameter DATA_W, default 8, data bits per frame.
- REQ-002: clk  input  1  rising-edge system clock.
- REQ-003: rst  input  1  reset, synchronous to clk, active-high.
- REQ-004: P_DATA  input  DATA_W  parallel byte to send; sampled only on acceptance.
- REQ-005: data_valid  input  1  request to send P_DATA.
- REQ-006: PAR_EN  input  1  1 = parity bit inserted after data.
- REQ-007: PAR_TYP  input  1  1 = odd parity, 0 = even parity.
- REQ-008: prescale  input  6  clk cycles per serial bit.
- REQ-009: TX_OUT  output  1  serial line, idle high.
- REQ-010: busy  output  1  high while a frame is in progress.
- REQ-011: tx_done  output  1  one-cycle pulse at the end of the stop bit.

Function
- REQ-012: The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
- REQ-013: In IDLE with data_valid=1, the block SHALL accept the request: latch P_DATA, PAR_EN, PAR_TYP and prescale, then enter START on the next edge.
- REQ-014: data_valid SHALL be ignored while busy=1; no queueing.
- REQ-015: Latency: TX_OUT SHALL go low and busy SHALL go high on the first edge after acceptance.
- REQ-016: Each bit SHALL hold TX_OUT for exactly the latched prescale cycles.
- REQ-017: A latched prescale of 0 SHALL be treated as 1.
- REQ-018: Input changes after acceptance SHALL NOT affect the current frame.
- REQ-019: START SHALL drive 0.
- REQ-020: DATA SHALL send DATA_W bits MSB first, P_DATA[DATA_W-1] down to P_DATA[0], using a bit counter that counts to DATA_W-1 and then clears.
- REQ-021: PARITY is entered only when the latched PAR_EN=1.
  - Odd (PAR_TYP=1): bit SHALL be ~^data.
  - Even (PAR_TYP=0): bit SHALL be ^data.
- REQ-022: STOP SHALL drive 1 for one bit time.
- REQ-023: At the end of STOP, tx_done SHALL pulse for one cycle, busy SHALL fall on the same edge, and the FSM SHALL return to IDLE.
- REQ-024: Frame length SHALL be (DATA_W+2+PAR_EN)*prescale cycles.
- REQ-025: Back-to-back frames SHALL be separated by at least one IDLE cycle at TX_OUT=1.
- REQ-026: TX_OUT SHALL be registered, with no combinational path from inputs.

Reset
- REQ-027: On rst=1 at a clk edge, the block SHALL go to IDLE, with outputs TX_OUT=1, busy=0, tx_done=0, and counters and latches cleared.
- REQ-028: Reset mid-frame SHALL abandon the frame immediately, with TX_OUT=1 on that edge and no tx_done.
- REQ-029: data_valid SHALL NOT be accepted in any cycle where rst=1.

Configuration
- REQ-030: Macro UART_TX_PARITY_EN defined: PARITY state and parity logic are compiled in and follow REQ-021.
- REQ-031: Macro UART_TX_PARITY_EN undefined: the PARITY state and its logic are absent, PAR_EN and PAR_TYP are ignored, and the frame is always DATA_W+2 bits.

Structure
- REQ-032: Package uart_pkg SHALL hold:
  - the FSM state enum typedef;
  - constants for the idle level (1), start level (0) and stop level (1);
  - the prescale width (6).
- REQ-033: Sub-module uart_tx_bit_timer SHALL own the prescale cycle counter and emit a one-cycle bit_end strobe.
  - It restarts on FSM state entry.
  - It is cleared by rst.

Verification
- REQ-034: rst 5 cycles, P_DATA=8'h09, PAR_EN=1, PAR_TYP=1, prescale=8 -> TX_OUT sequence 0,0,0,0,0,1,0,0,1,1(parity),1(stop), each 8 cycles; tx_done pulses at cycle 88 after acceptance.
- REQ-035: Same data with PAR_TYP=0 -> parity bit 0; with PAR_EN=0 -> no parity bit, tx_done pulses at cycle 80.
- REQ-036: data_valid pulsed again at cycle 20 mid-frame with P_DATA=8'hFF -> ignored; the frame still carries 8'h09.
- REQ-037: rst asserted at cycle 30 of a frame -> TX_OUT=1 and busy=0 on that edge, no tx_done; the next request sends a clean frame.
- REQ-038: prescale=0 with P_DATA=8'hA5, PAR_EN=0 -> 10-cycle frame at 1 cycle per bit.
- REQ-039: data_valid held high continuously with prescale=4, PAR_EN=0 -> consecutive frames 41 cycles apart, with exactly one idle-high cycle between frames.
